ddr4_cs_n_lane_ctrl: RTL and testbench
======================================

DDR4_CS_N_LANE_CTRL -- requirements
Module: ddr4_cs_n_lane_ctrl

Interface
REQ-001 SHALL have parameter MOVE_GAP, default 3: idle FAB_CLK cycles after each DELAY_LINE_MOVE_0 pulse (range 1..15).
REQ-002 SHALL have parameter TAP_INIT, default 1: tap count after reset or load, matching IOD TX_DELAY_VAL.
REQ-003 SHALL have parameter TAP_MAX, default 255: upper tap-count bound.
REQ-004 SHALL have ports, in this order:
- FAB_CLK  in  1  single clock.
- ARST_N  in  1  asynchronous active-low reset.
- DFI_CS_N  in  4  per-phase chip select; bit0 is driven on the wire first.
- CS_FORCE_HIGH  in  1  forces deselect on all phases.
- OE_ENABLE  in  1  output-enable request for the pad.
- TX_DATA_0  out  4  to IOD TX data.
- OE_DATA_0  out  4  to IOD OE data.
- DLY_REQ_VALID  in  1  delay-adjust request.
- DLY_REQ_DIR  in  1  1 = increment taps, 0 = decrement taps.
- DLY_REQ_STEPS  in  8  number of taps to move.
- DLY_REQ_LOAD  in  1  reload the delay line to its initial value.
- DLY_REQ_READY  out  1  controller idle.
- DELAY_LINE_MOVE_0  out  1  to IOD.
- DELAY_LINE_DIRECTION_0  out  1  to IOD.
- DELAY_LINE_LOAD_0  out  1  to IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from IOD.
- DLY_DONE  out  1  one-cycle completion pulse.
- DLY_ERR  out  1  sticky out-of-range flag.
- DLY_TAP_COUNT  out  8  current tap estimate.

Function
REQ-005 TX_DATA_0 SHALL be DFI_CS_N registered once, so latency is 1 cycle.
REQ-006 When CS_FORCE_HIGH is sampled high, TX_DATA_0 SHALL be 4'b1111 on the next cycle.
REQ-007 OE_DATA_0 SHALL be {4{OE_ENABLE}} registered, with 1-cycle latency aligned to TX_DATA_0.
REQ-008 The delay FSM SHALL have the states IDLE, LOAD, SETUP, MOVE, GAP and DONE.
REQ-009 DLY_REQ_READY SHALL be high only in IDLE; requests outside IDLE SHALL be ignored.
REQ-010 IDLE transitions:
- DLY_REQ_LOAD high -> LOAD; LOAD wins if DLY_REQ_VALID is also high.
- Else DLY_REQ_VALID high with STEPS > 0 -> SETUP; capture DIR and STEPS.
- Else DLY_REQ_VALID high with STEPS = 0 -> DONE; no move issued.
REQ-011 LOAD SHALL assert DELAY_LINE_LOAD_0 for exactly 1 cycle, set DLY_TAP_COUNT = TAP_INIT, clear DLY_ERR, then go to DONE.
REQ-012 SETUP SHALL last 1 cycle, driving DELAY_LINE_DIRECTION_0 = captured DIR, which is held stable from SETUP through the end of GAP.
REQ-013 MOVE SHALL assert DELAY_LINE_MOVE_0 for exactly 1 cycle, decrement the remaining-steps counter, and update DLY_TAP_COUNT by +1 or -1.
REQ-014 DLY_TAP_COUNT SHALL saturate at 0 and TAP_MAX and never wrap.
REQ-015 GAP SHALL last MOVE_GAP cycles, then:
- remaining > 0 -> MOVE;
- remaining = 0 -> DONE.
REQ-016 If DELAY_LINE_OUT_OF_RANGE_0 is sampled high in MOVE or GAP, the FSM SHALL:
- set DLY_ERR;
- abandon the remaining steps;
- go to DONE after the current GAP cycle.
REQ-017 DONE SHALL pulse DLY_DONE for 1 cycle, then return to IDLE.
REQ-018 The data path (REQ-005..007) SHALL be independent of the FSM state.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 ARST_N low SHALL asynchronously force the following; release SHALL be used synchronously in the FAB_CLK domain:
- FSM = IDLE;
- TX_DATA_0 = 4'b1111;
- OE_DATA_0 = 4'b0000;
- DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0 and DELAY_LINE_DIRECTION_0 = 0;
- DLY_DONE = 0 and DLY_ERR = 0;
- DLY_TAP_COUNT = TAP_INIT;
- DLY_REQ_READY = 0 while reset is asserted, 1 on the first cycle after release.
REQ-021 Reset asserted mid-move SHALL abort immediately, with no further MOVE pulse and no DONE pulse.

Structure
REQ-022 The FSM state encoding, TAP_INIT/TAP_MAX defaults and the MOVE_GAP bound SHALL live in shared package ddr4_phy_pkg.
REQ-023 The delay FSM SHALL be sub-module ddr4_dly_step_ctrl, reusable for the other PHY lanes; packing and OE registers stay in the top level.

Verification
REQ-024 Data path: DFI_CS_N = 4'b1110 with OE_ENABLE = 1 -> next cycle TX_DATA_0 = 4'b1110 and OE_DATA_0 = 4'b1111; CS_FORCE_HIGH = 1 -> next cycle TX_DATA_0 = 4'b1111.
REQ-025 Move up: DIR = 1, STEPS = 3, MOVE_GAP = 3 -> 3 single-cycle MOVE pulses spaced 4 cycles apart, DIRECTION high throughout, DLY_TAP_COUNT 1 -> 4, one DLY_DONE pulse.
REQ-026 Out-of-range: DIR = 0, STEPS = 5, DELAY_LINE_OUT_OF_RANGE_0 raised after the 2nd pulse -> exactly 2 pulses, DLY_ERR = 1, DLY_DONE pulses, DLY_TAP_COUNT = 0 (saturated).
REQ-027 Same-cycle LOAD and VALID in IDLE -> only a 1-cycle LOAD pulse, no MOVE, DLY_TAP_COUNT = TAP_INIT, DLY_ERR cleared.
REQ-028 ARST_N low during GAP of a STEPS = 4 move -> all outputs at reset values immediately, no DONE pulse; a new request after release is accepted.
REQ-029 STEPS = 0 request -> DLY_DONE 2 cycles after request, no MOVE pulse; VALID asserted while busy -> ignored.

Source files
------------

// File: rtl/ddr4_phy_pkg.sv
// Shared DDR4 PHY lane definitions: delay-FSM state encoding, tap defaults and
// the saturating tap-step helper used by every lane's delay controller.
package ddr4_phy_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int unsigned TAP_W        = 8;
  localparam int unsigned GAP_W        = 4;
  localparam int unsigned TAP_INIT_DEF = 1;
  localparam int unsigned TAP_MAX_DEF  = 255;
  localparam int unsigned MOVE_GAP_DEF = 3;
  localparam int unsigned MOVE_GAP_MIN = 1;
  localparam int unsigned MOVE_GAP_MAX = 15;

  // Tap estimate never wraps: clamps at zero and at the lane's upper bound.
  function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] tap,
                                                input logic             up,
                                                input logic [TAP_W-1:0] tap_max);
    if (up) return (tap >= tap_max) ? tap_max : tap + 8'd1;
    else    return (tap == '0) ? '0 : tap - 8'd1;
  endfunction

endpackage

// File: rtl/ddr4_cs_n_lane_ctrl_if.sv
// Delay-adjust request/status bundle between a lane and its delay-step controller,
// including the IOD delay-line strobes.
interface ddr4_cs_n_lane_ctrl_if;
  import ddr4_phy_pkg::*;

  logic             req_valid;
  logic             req_dir;
  logic [TAP_W-1:0] req_steps;
  logic             req_load;
  logic             req_ready;
  logic             move;
  logic             direction;
  logic             load;
  logic             out_of_range;
  logic             done;
  logic             err;
  logic [TAP_W-1:0] tap_count;

  modport master (
    output req_valid, req_dir, req_steps, req_load, out_of_range,
    input  req_ready, move, direction, load, done, err, tap_count
  );

  modport slave (
    input  req_valid, req_dir, req_steps, req_load, out_of_range,
    output req_ready, move, direction, load, done, err, tap_count
  );

endinterface

// File: rtl/ddr4_dly_step_ctrl.sv
// Delay-line step controller: turns a load or N-step request into spaced
// single-cycle MOVE strobes while tracking a saturating tap estimate.
module ddr4_dly_step_ctrl
  import ddr4_phy_pkg::*;
#(
  parameter int unsigned MOVE_GAP = MOVE_GAP_DEF,
  parameter int unsigned TAP_INIT = TAP_INIT_DEF,
  parameter int unsigned TAP_MAX  = TAP_MAX_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ddr4_cs_n_lane_ctrl_if.slave  dly
);

  localparam logic [TAP_W-1:0] TAP_INIT_L = TAP_W'(TAP_INIT);
  localparam logic [TAP_W-1:0] TAP_MAX_L  = TAP_W'(TAP_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(MOVE_GAP - 1);

  logic [2:0]       state_q, state_d;
  logic             dir_cap_q;
  logic [TAP_W-1:0] rem_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             abort_q;
  logic             move_q, load_q, dir_q, done_q, ready_q, err_q;
  logic [TAP_W-1:0] tap_q;
  logic             in_move_gap;
  logic             accept_move;

  assign in_move_gap = (state_q == ST_MOVE) || (state_q == ST_GAP);
  assign accept_move = (state_q == ST_IDLE) && dly.req_valid && !dly.req_load &&
                       (dly.req_steps != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dly.req_load)       state_d = ST_LOAD;
        else if (dly.req_valid) state_d = (dly.req_steps != '0) ? ST_SETUP : ST_DONE;
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SETUP: state_d = ST_MOVE;
      ST_MOVE:  state_d = ST_GAP;
      // An out-of-range seen in MOVE holds through one GAP cycle via abort_q.
      ST_GAP: begin
        if (dly.out_of_range || abort_q) state_d = ST_DONE;
        else if (gap_cnt_q == '0)        state_d = (rem_q != '0) ? ST_MOVE : ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes follow state_q one cycle later so every output leaves a flop;
  // ready looks ahead so it never advertises a state that is about to be left.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      dir_cap_q <= 1'b0;
      rem_q     <= '0;
      gap_cnt_q <= '0;
      abort_q   <= 1'b0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      tap_q     <= TAP_INIT_L;
    end else begin
      state_q <= state_d;
      move_q  <= (state_q == ST_MOVE);
      load_q  <= (state_q == ST_LOAD);
      done_q  <= (state_q == ST_DONE);
      ready_q <= (state_d == ST_IDLE);
      dir_q   <= dir_cap_q && ((state_q == ST_SETUP) || in_move_gap);

      if (accept_move) begin
        dir_cap_q <= dly.req_dir;
        rem_q     <= dly.req_steps;
        abort_q   <= 1'b0;
      end

      if (state_q == ST_MOVE) begin
        rem_q     <= rem_q - 8'd1;
        tap_q     <= tap_step(tap_q, dir_cap_q, TAP_MAX_L);
        gap_cnt_q <= GAP_LAST;
      end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - 4'd1;
      end

      if (state_q == ST_LOAD) begin
        tap_q <= TAP_INIT_L;
        err_q <= 1'b0;
      end

      if (in_move_gap && dly.out_of_range) begin
        err_q   <= 1'b1;
        abort_q <= 1'b1;
        rem_q   <= '0;
      end
    end
  end

  assign dly.req_ready = ready_q;
  assign dly.move      = move_q;
  assign dly.direction = dir_q;
  assign dly.load      = load_q;
  assign dly.done      = done_q;
  assign dly.err       = err_q;
  assign dly.tap_count = tap_q;

endmodule

// File: rtl/ddr4_cs_n_lane_ctrl.sv
// DDR4 CS_n lane: registers per-phase chip select and OE toward the IOD and
// hosts the delay-step controller for the lane's TX delay line.
module ddr4_cs_n_lane_ctrl
  import ddr4_phy_pkg::*;
#(
  parameter int unsigned MOVE_GAP = MOVE_GAP_DEF,
  parameter int unsigned TAP_INIT = TAP_INIT_DEF,
  parameter int unsigned TAP_MAX  = TAP_MAX_DEF
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic [3:0]       DFI_CS_N,
  input  logic             CS_FORCE_HIGH,
  input  logic             OE_ENABLE,
  output logic [3:0]       TX_DATA_0,
  output logic [3:0]       OE_DATA_0,
  input  logic             DLY_REQ_VALID,
  input  logic             DLY_REQ_DIR,
  input  logic [TAP_W-1:0] DLY_REQ_STEPS,
  input  logic             DLY_REQ_LOAD,
  output logic             DLY_REQ_READY,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  output logic             DELAY_LINE_LOAD_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0,
  output logic             DLY_DONE,
  output logic             DLY_ERR,
  output logic [TAP_W-1:0] DLY_TAP_COUNT
);

  logic [3:0] tx_q;
  logic [3:0] oe_q;

  // Chip select idles deselected (all ones) so the rank stays quiet out of reset.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tx_q <= '1;
      oe_q <= '0;
    end else begin
      tx_q <= CS_FORCE_HIGH ? '1 : DFI_CS_N;
      oe_q <= {4{OE_ENABLE}};
    end
  end

  assign TX_DATA_0 = tx_q;
  assign OE_DATA_0 = oe_q;

  ddr4_cs_n_lane_ctrl_if dly ();

  assign dly.req_valid    = DLY_REQ_VALID;
  assign dly.req_dir      = DLY_REQ_DIR;
  assign dly.req_steps    = DLY_REQ_STEPS;
  assign dly.req_load     = DLY_REQ_LOAD;
  assign dly.out_of_range = DELAY_LINE_OUT_OF_RANGE_0;

  ddr4_dly_step_ctrl #(
    .MOVE_GAP (MOVE_GAP),
    .TAP_INIT (TAP_INIT),
    .TAP_MAX  (TAP_MAX)
  ) u_dly_step_ctrl (
    .clk_i  (FAB_CLK),
    .rst_ni (ARST_N),
    .dly    (dly.slave)
  );

  assign DLY_REQ_READY          = dly.req_ready;
  assign DELAY_LINE_MOVE_0      = dly.move;
  assign DELAY_LINE_DIRECTION_0 = dly.direction;
  assign DELAY_LINE_LOAD_0      = dly.load;
  assign DLY_DONE               = dly.done;
  assign DLY_ERR                = dly.err;
  assign DLY_TAP_COUNT          = dly.tap_count;

endmodule

// File: tb/tb_ddr4_cs_n_lane_ctrl.sv
// Directed bench for ddr4_cs_n_lane_ctrl: data-path and delay-operation
// scoreboards with expectations queued at stimulus time.
module tb_ddr4_cs_n_lane_ctrl;
  import ddr4_phy_pkg::*;

  localparam int unsigned GAP   = 3;
  localparam int unsigned TINIT = TAP_INIT_DEF;
  localparam int unsigned TMAX  = TAP_MAX_DEF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cs_n = 4'b1111;
  logic       force_hi = 1'b0;
  logic       oe_en = 1'b0;
  logic [3:0] tx, oe;

  always #5 clk = ~clk;

  ddr4_cs_n_lane_ctrl_if bus ();

  ddr4_cs_n_lane_ctrl #(
    .MOVE_GAP (GAP),
    .TAP_INIT (TINIT),
    .TAP_MAX  (TMAX)
  ) dut (
    .FAB_CLK                   (clk),
    .ARST_N                    (rst_n),
    .DFI_CS_N                  (cs_n),
    .CS_FORCE_HIGH             (force_hi),
    .OE_ENABLE                 (oe_en),
    .TX_DATA_0                 (tx),
    .OE_DATA_0                 (oe),
    .DLY_REQ_VALID             (bus.req_valid),
    .DLY_REQ_DIR               (bus.req_dir),
    .DLY_REQ_STEPS             (bus.req_steps),
    .DLY_REQ_LOAD              (bus.req_load),
    .DLY_REQ_READY             (bus.req_ready),
    .DELAY_LINE_MOVE_0         (bus.move),
    .DELAY_LINE_DIRECTION_0    (bus.direction),
    .DELAY_LINE_LOAD_0         (bus.load),
    .DELAY_LINE_OUT_OF_RANGE_0 (bus.out_of_range),
    .DLY_DONE                  (bus.done),
    .DLY_ERR                   (bus.err),
    .DLY_TAP_COUNT             (bus.tap_count)
  );

  typedef struct packed {
    logic [7:0] moves;
    logic [7:0] up;
    logic [7:0] loads;
    logic [7:0] tap;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic [3:0] tx;
    logic [3:0] oe;
  } dp_t;

  exp_t sb[$];
  dp_t  dq[$];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Pulse monitor samples 2ns after each rising edge, clear of the negedge checks.
  int unsigned cyc = 0, mv_total = 0, mv_up_total = 0, done_total = 0, load_total = 0;
  int unsigned mv_t[$];
  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus.move) begin
      mv_total++;
      if (bus.direction) mv_up_total++;
      mv_t.push_back(cyc);
    end
    if (bus.done) done_total++;
    if (bus.load) load_total++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"},    32'(tx), 32'hF);
    chk({tag, "_oe"},    32'(oe), 32'h0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_move"},  32'(bus.move), 32'h0);
    chk({tag, "_dir"},   32'(bus.direction), 32'h0);
    chk({tag, "_load"},  32'(bus.load), 32'h0);
    chk({tag, "_done"},  32'(bus.done), 32'h0);
    chk({tag, "_err"},   32'(bus.err), 32'h0);
    chk({tag, "_tap"},   32'(bus.tap_count), 32'(TINIT));
  endtask

  task automatic dp_step(input logic [3:0] c, input logic f, input logic o);
    dp_t e;
    @(negedge clk);
    cs_n = c; force_hi = f; oe_en = o;
    e.tx = f ? 4'b1111 : c;
    e.oe = {4{o}};
    dq.push_back(e);
    @(negedge clk);
    e = dq.pop_front();
    chk("dp_tx", 32'(tx), 32'(e.tx));
    chk("dp_oe", 32'(oe), 32'(e.oe));
  endtask

  // lat = negedges after the request's drive negedge, minus one, when DONE is seen.
  task automatic run_op(input string tag, input logic dir, input logic [7:0] steps,
                        input logic ld, input exp_t e, input int unsigned oor_after,
                        input bit poke, output int unsigned lat);
    int unsigned mv0, up0, d0, l0;
    logic got;
    exp_t x;
    mv0 = mv_total; up0 = mv_up_total; d0 = done_total; l0 = load_total;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b1; bus.req_dir = dir; bus.req_steps = steps; bus.req_load = ld;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_load = 1'b0;
    chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'h0);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (oor_after != 0 && (mv_total - mv0) >= oor_after) bus.out_of_range = 1'b1;
      if (poke && i == 2) begin
        bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_steps = 8'd5;
      end else if (poke && i == 3) begin
        bus.req_valid = 1'b0; bus.req_load = 1'b0;
      end
      if (bus.done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'h1);
    chk({tag, "_ready_at_done"}, 32'(bus.req_ready), 32'h1);
    bus.out_of_range = 1'b0;
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(bus.done), 32'h0);
    x = sb.pop_front();
    chk({tag, "_moves"}, mv_total - mv0, 32'(x.moves));
    chk({tag, "_up"},    mv_up_total - up0, 32'(x.up));
    chk({tag, "_loads"}, load_total - l0, 32'(x.loads));
    chk({tag, "_dones"}, done_total - d0, 32'h1);
    chk({tag, "_tap"},   32'(bus.tap_count), 32'(x.tap));
    chk({tag, "_err"},   32'(bus.err), 32'(x.err));
  endtask

  initial begin
    int unsigned lat, base, m0, d0;
    logic got;
    bus.req_valid = 1'b0; bus.req_dir = 1'b0; bus.req_steps = '0;
    bus.req_load = 1'b0; bus.out_of_range = 1'b0;

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(bus.req_ready), 32'h1);

    dp_step(4'b1110, 1'b0, 1'b1);
    dp_step(4'b0000, 1'b1, 1'b1);
    dp_step(4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      dp_step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    // Move up 1 -> 4; third pulse on 10th cycle after capture, DONE 4 cycles later.
    base = mv_t.size();
    run_op("up3", 1'b1, 8'd3, 1'b0, '{moves: 8'd3, up: 8'd3, loads: 8'd0, tap: 8'd4, err: 1'b0},
           0, 1'b0, lat);
    chk("up3_latency", lat, 32'd14);
    chk("up3_pulse_count", mv_t.size() - base, 32'd3);
    for (int k = base + 1; k < mv_t.size(); k++)
      chk("up3_spacing", mv_t[k] - mv_t[k-1], 32'(GAP + 1));

    run_op("load_valid", 1'b1, 8'd3, 1'b1,
           '{moves: 8'd0, up: 8'd0, loads: 8'd1, tap: 8'(TINIT), err: 1'b0}, 0, 1'b0, lat);

    // From tap 1 downward: second pulse saturates at 0, OOR then stops the sequence.
    run_op("oor", 1'b0, 8'd5, 1'b0, '{moves: 8'd2, up: 8'd0, loads: 8'd0, tap: 8'd0, err: 1'b1},
           2, 1'b0, lat);

    run_op("load_clr", 1'b0, 8'd9, 1'b1,
           '{moves: 8'd0, up: 8'd0, loads: 8'd1, tap: 8'(TINIT), err: 1'b0}, 0, 1'b0, lat);

    run_op("steps0", 1'b1, 8'd0, 1'b0,
           '{moves: 8'd0, up: 8'd0, loads: 8'd0, tap: 8'(TINIT), err: 1'b0}, 0, 1'b0, lat);
    chk("steps0_latency", lat, 32'd1);

    run_op("busy_ign", 1'b1, 8'd2, 1'b0,
           '{moves: 8'd2, up: 8'd2, loads: 8'd0, tap: 8'd3, err: 1'b0}, 0, 1'b1, lat);
    m0 = mv_total; d0 = done_total;
    repeat (8) @(negedge clk);
    chk("busy_ign_quiet_moves", mv_total, m0);
    chk("busy_ign_quiet_dones", done_total, d0);

    // Reset asserted in the GAP after the first pulse of a 4-step move.
    m0 = mv_total; d0 = done_total;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_dir = 1'b1; bus.req_steps = 8'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mv_total != m0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_first_pulse", 32'(got), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
    repeat (10) @(negedge clk);
    chk("rst_mid_moves", mv_total - m0, 32'd1);
    chk("rst_mid_dones", done_total - d0, 32'd0);

    run_op("after_rst", 1'b1, 8'd1, 1'b0,
           '{moves: 8'd1, up: 8'd1, loads: 8'd0, tap: 8'd2, err: 1'b0}, 0, 1'b0, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
